// File: rtl/scan_resp_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_resp_analyzer
//  Purpose  : Response-side BIST block. It compacts the CUT scan bit and
//             parallel outputs into a MISR signature and counts compaction
//             cycles. On bist_end it checks both against golden values.
//  Revision : 1.0  initial release
// ============================================================================
module scan_resp_analyzer #(
   parameter int               SIG_W      = 16,
   parameter int               PAR_W      = 9,
   parameter logic [SIG_W-1:0] POLY       = 16'h1021,
   parameter logic [SIG_W-1:0] SEED       = '0,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000,
   parameter int               CNT_W      = 16,
   parameter logic [CNT_W-1:0] EXP_CNT    = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             comp_en,
   input  logic             scan_bit,
   input  logic [PAR_W-1:0] par_resp,
   input  logic             bist_end,
   output logic             busy,
   output logic             done,
   output logic             pass_nfail,
   output logic [SIG_W-1:0] signature,
   output logic [CNT_W-1:0] comp_cnt
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_COMPARE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t             r_state;
   logic [SIG_W-1:0]   r_misr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;

   logic [SIG_W-1:0]   w_data;
   logic [SIG_W-1:0]   w_misr_next;
   logic [CNT_W-1:0]   w_cnt_next;

   // SIG_W must be at least PAR_W+1 so that no response bit is dropped here.
   assign w_data      = SIG_W'({par_resp, scan_bit});
   assign w_misr_next = {r_misr[SIG_W-2:0], 1'b0}
                      ^ (r_misr[SIG_W-1] ? POLY : '0)
                      ^ w_data;
   // Saturate at all-ones so an overlong session can never alias EXP_CNT.
   assign w_cnt_next  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_misr  <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_misr  <= SEED;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            S_RUN: begin
               // A sample arriving with bist_end is still part of the session.
               if (comp_en) begin
                  r_misr <= w_misr_next;
                  r_cnt  <= w_cnt_next;
               end
               if (bist_end) begin
                  r_state <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               r_pass  <= (r_misr == GOLDEN_SIG) && (r_cnt == EXP_CNT);
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign pass_nfail = r_pass;
   assign signature  = r_misr;
   assign comp_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_resp_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_resp_analyzer
//  Purpose  : Directed vector bench for scan_resp_analyzer. Two instances that
//             differ only in golden signature share one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scan_resp_analyzer;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       start    = 1'b0;
   logic       comp_en  = 1'b0;
   logic       scan_bit = 1'b0;
   logic [0:0] par_resp = 1'b0;
   logic       bist_end = 1'b0;

   logic       a_busy, a_done, a_pass;
   logic [3:0] a_sig;
   logic [2:0] a_cnt;
   logic       b_busy, b_done, b_pass;
   logic [3:0] b_sig;
   logic [2:0] b_cnt;

   scan_resp_analyzer #(
      .SIG_W(4), .PAR_W(1), .POLY(4'h3), .SEED(4'h0),
      .GOLDEN_SIG(4'hB), .CNT_W(3), .EXP_CNT(3'd6)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start), .comp_en(comp_en),
      .scan_bit(scan_bit), .par_resp(par_resp), .bist_end(bist_end),
      .busy(a_busy), .done(a_done), .pass_nfail(a_pass),
      .signature(a_sig), .comp_cnt(a_cnt)
   );

   scan_resp_analyzer #(
      .SIG_W(4), .PAR_W(1), .POLY(4'h3), .SEED(4'h0),
      .GOLDEN_SIG(4'h5), .CNT_W(3), .EXP_CNT(3'd6)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start), .comp_en(comp_en),
      .scan_bit(scan_bit), .par_resp(par_resp), .bist_end(bist_end),
      .busy(b_busy), .done(b_done), .pass_nfail(b_pass),
      .signature(b_sig), .comp_cnt(b_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       ce;
      logic [1:0] d;
      logic       be;
      logic       busy;
      logic       done;
      logic       pa;
      logic       pb;
      logic [3:0] sig;
      logic [2:0] cnt;
   } vec_t;

   vec_t rows[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   simul_lo, simul_hi;

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got {busy,done,pass,sig,cnt}=%b required %b", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic ce, input logic [1:0] d, input logic be,
                      input logic bsy, input logic dn, input logic pa, input logic pb,
                      input logic [3:0] sg, input logic [2:0] cn);
      vec_t v;
      v.st = st; v.ce = ce; v.d = d; v.be = be;
      v.busy = bsy; v.done = dn; v.pa = pa; v.pb = pb; v.sig = sg; v.cnt = cn;
      rows.push_back(v);
   endtask

   task automatic drive(input logic st, input logic ce, input logic [1:0] d, input logic be);
      start    = st;
      comp_en  = ce;
      par_resp = d[1];
      scan_bit = d[0];
      bist_end = be;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_both(input string name, input logic bsy, input logic dn,
                             input logic pa, input logic pb,
                             input logic [3:0] sg, input logic [2:0] cn);
      check({name, "_a"}, {a_busy, a_done, a_pass, a_sig, a_cnt}, {bsy, dn, pa, sg, cn});
      check({name, "_b"}, {b_busy, b_done, b_pass, b_sig, b_cnt}, {bsy, dn, pb, sg, cn});
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive(rows[i].st, rows[i].ce, rows[i].d, rows[i].be);
         step();
         check_both($sformatf("row%0d", i), rows[i].busy, rows[i].done,
                    rows[i].pa, rows[i].pb, rows[i].sig, rows[i].cnt);
      end
      drive(1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   initial begin
      // Pass session, start ignored in RUN, inputs ignored in DONE
      add(1,0,2'd0,0, 1,0,0,0,4'h0,3'd0);
      add(0,1,2'd1,0, 1,0,0,0,4'h1,3'd1);
      add(0,1,2'd2,0, 1,0,0,0,4'h0,3'd2);
      add(0,1,2'd3,0, 1,0,0,0,4'h3,3'd3);
      add(0,1,2'd0,0, 1,0,0,0,4'h6,3'd4);
      add(0,1,2'd0,0, 1,0,0,0,4'hC,3'd5);
      add(0,1,2'd0,0, 1,0,0,0,4'hB,3'd6);
      add(1,0,2'd0,0, 1,0,0,0,4'hB,3'd6);
      add(0,0,2'd0,1, 1,0,0,0,4'hB,3'd6);
      add(0,0,2'd0,0, 0,1,1,0,4'hB,3'd6);
      add(0,1,2'd3,1, 0,1,1,0,4'hB,3'd6);
      // Restart from DONE with a single-bit fault in the third sample
      add(1,0,2'd0,0, 1,0,0,0,4'h0,3'd0);
      add(0,1,2'd1,0, 1,0,0,0,4'h1,3'd1);
      add(0,1,2'd2,0, 1,0,0,0,4'h0,3'd2);
      add(0,1,2'd2,0, 1,0,0,0,4'h2,3'd3);
      add(0,1,2'd0,0, 1,0,0,0,4'h4,3'd4);
      add(0,1,2'd0,0, 1,0,0,0,4'h8,3'd5);
      add(0,1,2'd0,0, 1,0,0,0,4'h3,3'd6);
      add(0,0,2'd0,1, 1,0,0,0,4'h3,3'd6);
      add(0,0,2'd0,0, 0,1,0,0,4'h3,3'd6);
      // Seven compactions: signature 5 matches dut_b but count does not
      add(1,0,2'd0,0, 1,0,0,0,4'h0,3'd0);
      add(0,1,2'd1,0, 1,0,0,0,4'h1,3'd1);
      add(0,1,2'd2,0, 1,0,0,0,4'h0,3'd2);
      add(0,1,2'd3,0, 1,0,0,0,4'h3,3'd3);
      add(0,1,2'd0,0, 1,0,0,0,4'h6,3'd4);
      add(0,1,2'd0,0, 1,0,0,0,4'hC,3'd5);
      add(0,1,2'd0,0, 1,0,0,0,4'hB,3'd6);
      add(0,1,2'd0,0, 1,0,0,0,4'h5,3'd7);
      add(0,0,2'd0,1, 1,0,0,0,4'h5,3'd7);
      add(0,0,2'd0,0, 0,1,0,0,4'h5,3'd7);
      // Last sample coincides with bist_end
      simul_lo = rows.size();
      add(1,0,2'd0,0, 1,0,0,0,4'h0,3'd0);
      add(0,1,2'd1,0, 1,0,0,0,4'h1,3'd1);
      add(0,1,2'd2,0, 1,0,0,0,4'h0,3'd2);
      add(0,1,2'd3,0, 1,0,0,0,4'h3,3'd3);
      add(0,1,2'd0,0, 1,0,0,0,4'h6,3'd4);
      add(0,1,2'd0,0, 1,0,0,0,4'hC,3'd5);
      add(0,1,2'd0,1, 1,0,0,0,4'hB,3'd6);
      add(0,0,2'd0,0, 0,1,1,0,4'hB,3'd6);
      simul_hi = rows.size() - 1;
      // Counter saturates at 7 rather than wrapping
      add(1,0,2'd0,0, 1,0,0,0,4'h0,3'd0);
      for (int k = 1; k <= 8; k++) begin
         add(0,1,2'd0,0, 1,0,0,0,4'h0,(k > 7) ? 3'd7 : 3'(k));
      end
      add(0,0,2'd0,1, 1,0,0,0,4'h0,3'd7);
      add(0,0,2'd0,0, 0,1,0,0,4'h0,3'd7);

      // Reset state
      step();
      check_both("reset", 0,0,0,0,4'h0,3'd0);
      reset = 1'b0;

      // bist_end and comp_en in IDLE produce nothing
      drive(1'b0, 1'b1, 2'b11, 1'b1);
      step();
      check_both("idle_end0", 0,0,0,0,4'h0,3'd0);
      step();
      check_both("idle_end1", 0,0,0,0,4'h0,3'd0);
      drive(1'b0, 1'b0, 2'b00, 1'b0);
      step();
      check_both("idle_end2", 0,0,0,0,4'h0,3'd0);

      run_rows(0, rows.size() - 1);

      // Async reset between edges in the middle of a session
      drive(1'b1, 1'b0, 2'b00, 1'b0);
      step();
      drive(1'b0, 1'b1, 2'b01, 1'b0);
      step();
      drive(1'b0, 1'b1, 2'b11, 1'b0);
      step();
      check_both("pre_areset", 1,0,0,0,4'h1,3'd2);
      drive(1'b0, 1'b0, 2'b00, 1'b0);
      #3 reset = 1'b1;
      #1;
      check_both("areset", 0,0,0,0,4'h0,3'd0);
      reset = 1'b0;
      step();
      check_both("post_areset", 0,0,0,0,4'h0,3'd0);

      // Full rerun after reset must pass again
      run_rows(simul_lo, simul_hi);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scan_resp_analyzer.md
Name: scan_resp_analyzer

Overview:
Response-side BIST block. It is the receiving end of the pattern/scan path: it takes the circuit-under-test scan_out bit and the CUT parallel outputs, compacts them each enabled cycle into a MISR signature, and counts compactions. When the BIST controller signals bist_end, it compares the signature and the count against golden values and reports pass_nfail. It sits beside the LFSR pattern generators and the controller, and its result drives the top-level pass_nfail.

Parameters:
SIG_W, 16, MISR/signature width (must be >= PAR_W+1)
PAR_W, 9, width of CUT parallel response bus
POLY, 16'h1021, MISR feedback polynomial (Galois, applied when MSB shifts out)
SEED, 0, MISR value loaded on start
GOLDEN_SIG, 16'h0000, expected final signature
EXP_CNT, 0, expected number of compaction cycles
CNT_W, 16, compaction counter width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  1-cycle pulse; begins a session (mirrors bist_start edge)
comp_en  in  1  compact this cycle's response (shift or capture cycle)
scan_bit  in  1  CUT scan_out
par_resp  in  PAR_W  CUT parallel outputs
bist_end  in  1  end of test from controller; triggers compare
busy  out  1  session in progress (RUN or COMPARE)
done  out  1  result valid; held until next start or reset
pass_nfail  out  1  1 = signature and count match; valid only when done=1
signature  out  SIG_W  current MISR contents
comp_cnt  out  CNT_W  compactions since start

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, pass_nfail=0, signature=0, comp_cnt=0.
- FSM: IDLE, RUN, COMPARE, DONE.
- IDLE: start -> RUN; misr<=SEED, comp_cnt<=0, done<=0, pass_nfail<=0.
- RUN: busy=1. Each cycle with comp_en=1: misr <= {misr[SIG_W-2:0],1'b0} ^ (misr[SIG_W-1] ? POLY : 0) ^ D, where D = zero-extended {par_resp, scan_bit} (scan_bit is the LSB); comp_cnt <= comp_cnt+1, saturating at all-ones (no wrap).
- RUN with bist_end=1 -> COMPARE. If comp_en=1 in the same cycle, that sample is compacted first.
- RUN: start is ignored. comp_en outside RUN is ignored; misr and comp_cnt hold.
- COMPARE, one cycle, busy=1: pass_nfail <= (misr==GOLDEN_SIG) && (comp_cnt==EXP_CNT); done<=1; -> DONE.
- Latency: bist_end is sampled at edge t; done and pass_nfail are registered at edge t+1.
- DONE: busy=0; done, pass_nfail, signature and comp_cnt hold. bist_end and comp_en are ignored. start -> RUN with the same reinit as from IDLE; done drops on that edge.
- bist_end in IDLE: ignored; no result is produced.
- Reset mid-session: immediate return to IDLE with all outputs cleared.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Test parameters: SIG_W=4, PAR_W=1, POLY=4'h3, SEED=0, GOLDEN_SIG=4'hB, EXP_CNT=6.
- Pass case: start, then comp_en for 6 cycles with {par,scan} = 01,10,11,00,00,00, then bist_end -> signature steps 1,0,3,6,C,B; done=1 and pass_nfail=1 two edges after bist_end; comp_cnt=6.
- Single-bit fault: same sequence with the 3rd sample = 10 -> final signature differs from 4'hB; done=1, pass_nfail=0.
- Count mismatch: a 7th comp_en with data 00 (signature 4'h5) -> pass_nfail=0. Repeat with GOLDEN_SIG=4'h5, EXP_CNT=6 -> still 0 (count check).
- Simultaneous: 6th sample presented in the same cycle as bist_end -> compacted; pass_nfail=1. start during RUN is ignored (count and signature unchanged). bist_end in IDLE -> done stays 0.
- Async reset asserted mid-RUN between clock edges -> busy, signature and comp_cnt go to 0 immediately. A new start then a full rerun -> pass_nfail=1. start from DONE -> done drops, signature=SEED.
